// File: rtl/tone_meter.sv
// Tone meter: hysteresis zero-crossing detector, period/amplitude capture, lock tracking and a
// serial restoring divider that turns the period into a phase-increment estimate.
module tone_meter #(
  parameter int unsigned HYST     = 4,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned TOL      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample,
  output logic [9:0] period,
  output logic [5:0] freq_est,
  output logic       freq_valid,
  output logic [6:0] amplitude,
  output logic       locked,
  output logic       ovr
);

  localparam logic [7:0]  NegThr = 8'(127 - HYST);
  localparam logic [7:0]  PosThr = 8'(128 + HYST);
  localparam int unsigned MW     = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {StAcq, StNeg, StPos} state_e;

  state_e        state_q;
  logic [9:0]    cnt_q;
  logic          first_q;
  logic [MW-1:0] match_q;
  logic          locked_q;
  logic [7:0]    max_q;
  logic [6:0]    amp_q;
  logic [9:0]    period_q;
  logic          ovr_q;
  logic [3:0]    div_cnt_q;
  logic [9:0]    rem_q;
  logic [9:0]    quo_q;
  logic [9:0]    dvs_q;
  logic [5:0]    freq_q;
  logic          fv_q;

  logic        crossing;
  logic        timeout;
  logic        div_busy;
  logic [9:0]  diff;
  logic        period_match;
  logic [9:0]  dividend;
  logic [10:0] rem_sh;
  logic [9:0]  rem_sub;
  logic        rem_ge;

  assign crossing     = (state_q == StNeg) && (sample >= PosThr);
  // One-shot on the clock cnt steps into 1023; a crossing in the same clock takes priority.
  assign timeout      = !crossing && (cnt_q == 10'd1022);
  assign div_busy     = (div_cnt_q != 4'd0);
  assign diff         = (cnt_q >= period_q) ? (cnt_q - period_q) : (period_q - cnt_q);
  assign period_match = (diff <= 10'(TOL));
  assign dividend     = 10'd256 + {1'b0, cnt_q[9:1]};
  assign rem_sh       = {rem_q, quo_q[9]};
  assign rem_sub      = rem_sh[9:0] - dvs_q;
  assign rem_ge       = (rem_sh >= {1'b0, dvs_q});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StAcq;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      match_q   <= '0;
      locked_q  <= 1'b0;
      max_q     <= 8'h80;
      amp_q     <= '0;
      period_q  <= '0;
      ovr_q     <= 1'b0;
      div_cnt_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      freq_q    <= '0;
      fv_q      <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      fv_q  <= 1'b0;

      // Divider: 10 quotient steps, then one clock to publish the saturated result.
      if (div_busy) begin
        div_cnt_q <= div_cnt_q - 4'd1;
        if (div_cnt_q == 4'd1) begin
          fv_q   <= 1'b1;
          freq_q <= (quo_q > 10'd63) ? 6'd63 : quo_q[5:0];
        end else begin
          rem_q <= rem_ge ? rem_sub : rem_sh[9:0];
          quo_q <= {quo_q[8:0], rem_ge};
        end
      end

      if (crossing) begin
        state_q <= StPos;
        cnt_q   <= 10'd1;
        first_q <= 1'b1;
        amp_q   <= 7'(max_q - 8'h80);
        max_q   <= 8'h80;
        if (first_q) begin
          period_q <= cnt_q;
          if (period_match) begin
            if (match_q != MW'(LOCK_CNT)) match_q <= match_q + MW'(1);
            if (match_q >= MW'(LOCK_CNT - 1)) locked_q <= 1'b1;
          end else begin
            match_q  <= '0;
            locked_q <= 1'b0;
          end
          if (div_busy) begin
            ovr_q <= 1'b1;
          end else begin
            div_cnt_q <= 4'd11;
            rem_q     <= '0;
            quo_q     <= dividend;
            dvs_q     <= cnt_q;
          end
        end
      end else if (timeout) begin
        state_q  <= StAcq;
        cnt_q    <= 10'd1023;
        first_q  <= 1'b0;
        match_q  <= '0;
        locked_q <= 1'b0;
      end else begin
        if (cnt_q != 10'd1023) cnt_q <= cnt_q + 10'd1;
        if (state_q != StNeg && sample <= NegThr) state_q <= StNeg;
        if (state_q == StPos && sample > max_q) max_q <= sample;
      end
    end
  end

  assign period     = period_q;
  assign freq_est   = freq_q;
  assign freq_valid = fv_q;
  assign amplitude  = amp_q;
  assign locked     = locked_q;
  assign ovr        = ovr_q;

endmodule

// File: tb/tb_tone_meter.sv
// Directed bench for tone_meter: sine/square/jitter stimulus, per-clock pulse timing from a small
// crossing/divider-occupancy model, and hand-computed period/frequency/lock values.
module tb_tone_meter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sample = 8'h80;
  logic [9:0] period;
  logic [5:0] freq_est;
  logic       freq_valid;
  logic [6:0] amplitude;
  logic       locked;
  logic       ovr;

  int n_checks = 0;
  int n_pass   = 0;

  // Event model: polarity state (0 ACQ, 1 NEG, 2 POS), counter, first flag, divider age.
  int m_st    = 0;
  int m_cnt   = 0;
  int m_age   = 0;
  bit m_first = 1'b0;
  bit cross_now;
  int ph  = 0;
  int inc = 1;

  tone_meter #(
    .HYST    (4),
    .LOCK_CNT(4),
    .TOL     (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sample    (sample),
    .period    (period),
    .freq_est  (freq_est),
    .freq_valid(freq_valid),
    .amplitude (amplitude),
    .locked    (locked),
    .ovr       (ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [7:0] sine_at(input int p);
    real x;
    x = 128.0 + 127.0 * $sin(6.283185307179586 * real'(p) / 256.0);
    return 8'($rtoi(x + 0.5));
  endfunction

  task automatic tick(input logic [7:0] s);
    bit busy;
    bit exp_fv;
    bit exp_ovr;
    bit cap;
    sample = s;
    @(posedge clk);
    #1;
    cross_now = 1'b0;
    exp_fv    = 1'b0;
    exp_ovr   = 1'b0;
    cap       = 1'b0;
    if (rst) begin
      m_st = 0; m_cnt = 0; m_first = 1'b0; m_age = 0;
    end else begin
      busy = (m_age != 0);
      if (busy) m_age++;
      if (m_age == 12) begin
        exp_fv = 1'b1;
        m_age  = 0;
      end
      if (m_st == 1 && s >= 8'h84) begin
        cross_now = 1'b1;
        cap       = m_first;
        m_first   = 1'b1;
        m_st      = 2;
        m_cnt     = 1;
        if (cap && busy) exp_ovr = 1'b1;
        else if (cap) m_age = 1;
      end else if (m_cnt == 1022) begin
        m_cnt = 1023; m_st = 0; m_first = 1'b0;
      end else begin
        if (m_cnt != 1023) m_cnt++;
        if (m_st != 1 && s <= 8'h7B) m_st = 1;
      end
    end
    check("freq_valid", freq_valid, exp_fv);
    check("ovr", ovr, exp_ovr);
  endtask

  task automatic run_clocks(input int k);
    for (int i = 0; i < k; i++) begin
      tick(sine_at(ph));
      ph = (ph + inc) % 256;
    end
  endtask

  task automatic run_tone(input int n);
    int seen  = 0;
    int guard = 0;
    while (seen < n && guard < 3000) begin
      tick(sine_at(ph));
      ph = (ph + inc) % 256;
      guard++;
      if (cross_now) seen++;
    end
    if (seen < n) check("tone_budget", seen, n);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, period, 0);
    check({tag, "_freq"}, freq_est, 0);
    check({tag, "_amp"}, amplitude, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_fv"}, freq_valid, 0);
    check({tag, "_ovr"}, ovr, 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick(8'h80);
    check_zero("rst");
    rst = 1'b0;

    // Increment-1 sine: 256-clock period, lock on the 6th crossing.
    ph = 0; inc = 1;
    for (int n = 1; n <= 9; n++) begin
      run_tone(1);
      check("t1_period", period, (n == 1) ? 0 : 256);
      check("t1_amp", amplitude, (n == 1) ? 0 : 127);
      check("t1_locked", locked, (n >= 6) ? 1 : 0);
      check("t1_freq", freq_est, (n <= 2) ? 0 : 1);
    end

    // Step to period 128; phase 4 keeps the first new period exactly 128.
    ph = 4; inc = 2;
    for (int n = 0; n <= 4; n++) begin
      run_tone(1);
      check("step_period", period, 128);
      check("step_locked", locked, (n == 4) ? 1 : 0);
      check("step_freq", freq_est, (n == 0) ? 1 : 2);
    end

    // Increment-4 sine: period 64, freq 4.
    rst = 1'b1; tick(8'h80); rst = 1'b0;
    ph = 0; inc = 4;
    for (int n = 1; n <= 4; n++) begin
      run_tone(1);
      check("t2_period", period, (n == 1) ? 0 : 64);
      check("t2_freq", freq_est, (n <= 2) ? 0 : 4);
    end

    // Reset five clocks after a capture aborts the division.
    run_clocks(4);
    rst = 1'b1;
    run_clocks(1);
    rst = 1'b0;
    check_zero("midrst");
    run_tone(2);
    check("resume_period", period, 64);
    check("resume_freq0", freq_est, 0);
    run_clocks(12);
    check("resume_freq", freq_est, 4);
    run_tone(4);
    check("resume_locked", locked, 1);

    // Hold at midscale until the counter saturates.
    for (int i = 0; i < 1100; i++) begin
      tick(8'h80);
      if (m_cnt >= 1020) check("tmo_locked", locked, (m_cnt != 1023) ? 1 : 0);
    end
    check("tmo_period", period, 64);
    ph = 0; inc = 4;
    for (int n = 1; n <= 5; n++) begin
      run_tone(1);
      check("rt_period", period, 64);
      check("rt_locked", locked, (n == 5) ? 1 : 0);
    end

    // Crossing on the very clock the counter would saturate wins over the timeout.
    for (int i = 0; i < 1100 && m_cnt != 1022; i++) tick(8'h00);
    tick(8'hFF);
    check("race_period", period, 1022);
    check("race_locked", locked, 0);
    tick(8'h00);
    tick(8'hFF);
    check("race_next", period, 2);
    repeat (12) tick(8'h00);
    check("race_freq", freq_est, 0);

    // Square wave: period 4, saturated estimate, overruns while busy.
    rst = 1'b1; tick(8'h80); rst = 1'b0;
    for (int i = 0; i < 48; i++) tick(((i % 4) < 2) ? 8'hFF : 8'h00);
    check("sq_period", period, 4);
    check("sq_freq", freq_est, 63);
    check("sq_amp", amplitude, 127);

    // Jitter inside the hysteresis band must not cross.
    rst = 1'b1; tick(8'h80); rst = 1'b0;
    for (int i = 0; i < 300; i++) tick(8'h7C + 8'((i * 5) % 8));
    check("jit_period", period, 0);
    ph = 0; inc = 4;
    run_tone(1);
    check("jit_first", period, 0);
    run_tone(1);
    check("jit_cap", period, 64);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tone_meter.md
TONE_METER -- requirements
Module: tone_meter

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: HYST, 4, hysteresis half-width in LSBs around midscale.
REQ-002 Parameters SHALL include: LOCK_CNT, 4, number of consecutive matching periods required for lock.
REQ-003 Parameters SHALL include: TOL, 1, maximum allowed difference in clocks between consecutive periods that counts as a match.
REQ-004 Port clk SHALL be an input, 1 bit wide, and is the single clock; all logic is on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit wide; reset is synchronous and active-high.
REQ-006 Port sample SHALL be an input, 8 bits wide: an offset-binary sine sample taken every clock, where 0x80 is zero and 0x80 and above is the positive half.
REQ-007 Port period SHALL be an output, 10 bits wide: the last captured crossing-to-crossing period in clocks.
REQ-008 Port freq_est SHALL be an output, 6 bits wide: the estimated phase increment, round(256/period).
REQ-009 Port freq_valid SHALL be an output, 1 bit wide: a one-clock pulse when freq_est updates.
REQ-010 Port amplitude SHALL be an output, 7 bits wide: the peak of the last positive half minus 0x80.
REQ-011 Port locked SHALL be an output, 1 bit wide: high while the period is stable.
REQ-012 Port ovr SHALL be an output, 1 bit wide: a one-clock pulse when a crossing arrives while the divider is busy.

Function
REQ-013 The polarity FSM SHALL have states ACQ, NEG and POS; the reset state is ACQ.
REQ-014 From ACQ or POS, the FSM SHALL go to NEG when sample <= 0x7F-HYST.
REQ-015 From NEG, the FSM SHALL go to POS when sample >= 0x80+HYST; that NEG->POS edge is the rising crossing.
REQ-016 Samples inside the hysteresis band SHALL hold the current state; ACQ never goes directly to POS.
REQ-017 The 10-bit counter cnt SHALL be loaded with 1 on every rising crossing and SHALL increment by 1 on every other clock.
REQ-018 cnt SHALL saturate at 1023; on reaching 1023 the block SHALL clear locked, clear the match count, clear the first-crossing flag and move the FSM to ACQ, with period left unchanged.
REQ-019 On a rising crossing with the first-crossing flag set, period SHALL be loaded with cnt, so an exact cycle gives period = P.
REQ-020 On a rising crossing with the first-crossing flag clear, the block SHALL only set the flag and capture nothing.
REQ-021 The divider SHALL be a sequential restoring divider computing (256 + floor(period/2)) / period at 1 quotient bit per clock over 10 clocks.
REQ-022 The divider operands SHALL be latched on the capture clock.
REQ-023 freq_est SHALL be loaded and freq_valid pulsed 11 clocks after the capture clock.
REQ-024 A quotient above 63 SHALL saturate freq_est to 63; a period of 1 SHALL give 63.
REQ-025 A capture while the divider is busy SHALL update period, SHALL pulse ovr for that clock, and SHALL neither restart nor alter the division in flight.
REQ-026 A running maximum SHALL track the peak sample while the FSM is in POS.
REQ-027 On each rising crossing, amplitude SHALL be loaded with max-0x80 (7 bits) and the maximum cleared to 0x80; this also applies on the first crossing.
REQ-028 On each capture after the first, if |period_new - period_prev| <= TOL the match count SHALL increment, saturating at LOCK_CNT; otherwise it SHALL clear to 0 and locked SHALL be cleared in the same clock.
REQ-029 locked SHALL assert on the capture clock at which the match count reaches LOCK_CNT.
REQ-030 A timeout and a crossing in the same clock SHALL resolve as the crossing winning.

Reset
REQ-031 While rst is high, all outputs SHALL be 0, the FSM SHALL be in ACQ, cnt SHALL be 0, the divider SHALL be idle, and the first-crossing flag, match count and maximum (set to 0x80) SHALL be cleared.
REQ-032 Reset asserted mid-division SHALL abort the division, and no freq_valid SHALL follow.

Verification
REQ-033 Full-scale sine with increment 1 (256-clock period), run for 8 cycles -> period = 256, freq_est = 1, amplitude = 0x7F, locked high from the 6th rising crossing.
REQ-034 Sine with increment 4 -> period = 64, freq_est = 4, freq_valid exactly 11 clocks after each capture.
REQ-035 Square wave alternating 0xFF/0x00 every 2 clocks -> period = 4, freq_est = 63 (saturated), ovr pulsed on captures that arrive while the divider is busy.
REQ-036 Locked tone, then sample held at 0x80 for 1100 clocks -> locked falls when cnt reaches 1023, FSM in ACQ, period unchanged, and the next tone needs two crossings before any capture.
REQ-037 Sample jittering within 0x7C..0x83 -> no FSM transitions, no captures; a single step of period 256 to period 128 -> match count cleared, locked low, and locked high again after 4 matching captures.
REQ-038 rst pulsed 5 clocks after a capture -> no freq_valid, all outputs 0, and correct measurement resumes afterwards.
